// File: rtl/ddr_sched_pkg.sv
// ---------------------------------------------------------------------------
// ddr_sched_pkg
// Shared types and default constants for the DDR burst scheduler.
//   state_t : scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   owner_t : which requester holds the AXI master (OWN_WR = ADC capture,
//             OWN_RD = Ethernet readback)
//   DEF_BURST_BYTES / DEF_TIMEOUT_CYC : parameter defaults for the top
// ---------------------------------------------------------------------------
package ddr_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef enum logic {OWN_WR, OWN_RD} owner_t;

  // 16 beats x 32 bit per AXI burst
  localparam int DEF_BURST_BYTES = 64;
  localparam int DEF_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/ddr_sched_rr_arb.sv
// ---------------------------------------------------------------------------
// ddr_sched_rr_arb
// Two-input round-robin arbiter. When both sides request together, the side
// that was not served last wins; after reset the write side wins.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_req_wr/i_req_rd pending requests
//   i_grant_en       arbitration allowed this cycle (scheduler idle)
//   i_update         a run just completed; move the pointer past i_served
//   i_served         owner of the run that just completed
//   o_grant          a grant is issued this cycle
//   o_owner          side being granted
// ---------------------------------------------------------------------------
module ddr_sched_rr_arb
  import ddr_sched_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_req_wr,
  input  logic   i_req_rd,
  input  logic   i_grant_en,
  input  logic   i_update,
  input  owner_t i_served,
  output logic   o_grant,
  output owner_t o_owner
);

  // r_prio names the side that wins a tie; it always points away from the
  // side served most recently.
  owner_t r_prio;

  // Priority pointer: hand the tie-break to the other side once a run ends.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prio <= OWN_WR;
    end else if (i_update) begin
      r_prio <= (i_served == OWN_WR) ? OWN_RD : OWN_WR;
    end
  end

  // Grant selection: a lone requester always wins, ties go to r_prio.
  always_comb begin
    o_grant = i_grant_en && (i_req_wr || i_req_rd);
    o_owner = OWN_WR;
    if (i_req_wr && i_req_rd) begin
      o_owner = r_prio;
    end else if (i_req_rd) begin
      o_owner = OWN_RD;
    end
  end

endmodule

// File: rtl/ddr_burst_scheduler.sv
// ---------------------------------------------------------------------------
// ddr_burst_scheduler
// Shares one AXI-Full master between the ADC write path and the Ethernet
// read path. A granted request runs as N fixed-size bursts: one INIT pulse
// per burst, base address advancing by BURST_BYTES, waiting for a rising
// edge of TXN_DONE each time. Errors are OR-ed into a one-cycle ack.
// Optional feature macro: DDR_SCHED_TIMEOUT_EN -- bounds each burst wait to
// TIMEOUT_CYC cycles; on expiry the run ends with err=1.
// Ports:
//   ACLK, ARESET                 clock, asynchronous active-high reset
//   wr_req/wr_addr/wr_len        write request (level, held until wr_ack)
//   wr_ack/wr_err                one-cycle completion pulse and its status
//   rd_req/rd_addr/rd_len        read request
//   rd_ack/rd_err                read completion pulse and status
//   m_init_txn                   one-cycle burst start to the AXI master
//   m_base_addr/m_dir            burst address and direction (1 = read)
//   m_txn_done/m_error           master completion level and error flag
//   busy                         scheduler not idle
//   owner                        current/last grant (0 = wr, 1 = rd)
// ---------------------------------------------------------------------------
module ddr_burst_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int BURST_BYTES = DEF_BURST_BYTES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_ack,
  output logic              rd_err,
  output logic              m_init_txn,
  output logic [ADDR_W-1:0] m_base_addr,
  output logic              m_dir,
  input  logic              m_txn_done,
  input  logic              m_error,
  output logic              busy,
  output logic              owner
);

  state_t            r_state;
  state_t            w_next_state;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_err_acc;
  logic              r_done_prev;

  logic              w_grant;
  owner_t            w_grant_owner;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LEN_W-1:0]  w_sel_len;
  logic              w_done_edge;
  logic              w_timeout;

  // TXN_DONE is a level from the master; only its rising edge counts.
  assign w_done_edge = m_txn_done & ~r_done_prev;

  ddr_sched_rr_arb u_arb (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_req_wr   (wr_req),
    .i_req_rd   (rd_req),
    .i_grant_en (r_state == IDLE),
    .i_update   (r_state == RESP),
    .i_served   (r_owner),
    .o_grant    (w_grant),
    .o_owner    (w_grant_owner)
  );

  assign w_sel_addr = (w_grant_owner == OWN_RD) ? rd_addr : wr_addr;
  assign w_sel_len  = (w_grant_owner == OWN_RD) ? rd_len  : wr_len;

`ifdef DDR_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Burst watchdog: restarts on every ISSUE, counts WAIT cycles.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_tmo_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_timeout = (r_state == WAIT) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC == 0);
  assign w_timeout    = 1'b0;
`endif

  // State register plus the done-edge history, which keeps tracking the
  // master in every state so a stale high level never looks like a new edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= IDLE;
      r_done_prev <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_done_prev <= m_txn_done;
    end
  end

  // Next-state logic. A zero-length request skips straight to RESP, and an
  // errored burst aborts whatever bursts are left.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_next_state = (w_sel_len == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: w_next_state = WAIT;
      WAIT: begin
        if (w_done_edge) begin
          w_next_state = (m_error || (r_remaining == LEN_W'(1))) ? RESP : ISSUE;
        end else if (w_timeout) begin
          w_next_state = RESP;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Run context: latched at grant, stepped on each done edge. The address
  // wraps silently at the top of the address space.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_owner     <= OWN_WR;
      r_addr      <= '0;
      r_remaining <= '0;
      r_err_acc   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner     <= w_grant_owner;
            r_addr      <= w_sel_addr;
            r_remaining <= w_sel_len;
            r_err_acc   <= 1'b0;
          end
        end
        WAIT: begin
          if (w_done_edge) begin
            r_err_acc   <= r_err_acc | m_error;
            r_remaining <= r_remaining - LEN_W'(1);
            r_addr      <= r_addr + ADDR_W'(BURST_BYTES);
          end else if (w_timeout) begin
            r_err_acc <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode straight from registers, so reset clears them at once.
  assign m_init_txn  = (r_state == ISSUE);
  assign m_base_addr = r_addr;
  assign m_dir       = r_owner;
  assign owner       = r_owner;
  assign busy        = (r_state != IDLE);
  assign wr_ack      = (r_state == RESP) && (r_owner == OWN_WR);
  assign rd_ack      = (r_state == RESP) && (r_owner == OWN_RD);
  assign wr_err      = wr_ack && r_err_acc;
  assign rd_err      = rd_ack && r_err_acc;

endmodule

// File: tb/tb_ddr_burst_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ddr_burst_scheduler
// Scoreboarded bench for ddr_burst_scheduler. Each request pushes its
// expected init pulses and ack (with predicted cycle numbers) onto a queue;
// a monitor pops and compares as the DUT produces them. A behavioural AXI
// master answers each init with a one-cycle done after a fixed latency.
// With DDR_SCHED_TIMEOUT_EN defined, the burst watchdog is exercised too.
// ---------------------------------------------------------------------------
module tb_ddr_burst_scheduler;

  localparam int MST_LAT = 20;
  localparam int TB_TMO  = 16;

  typedef struct {
    bit          isAck;
    bit          side;
    logic [31:0] addr;
    bit          err;
    int          cyc;
  } sbItem_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        wr_req, rd_req;
  logic [31:0] wr_addr, rd_addr;
  logic [15:0] wr_len, rd_len;
  logic        wr_ack, wr_err, rd_ack, rd_err;
  logic        m_init_txn, m_dir, m_txn_done, m_error, busy, owner;
  logic [31:0] m_base_addr;

  sbItem_t sbQ[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      mstBursts;
  int      mstErrBurst;
  bit      mstHold;
  bit      tbPrioRd;

  ddr_burst_scheduler #(
    .ADDR_W      (32),
    .LEN_W       (16),
    .BURST_BYTES (64),
    .TIMEOUT_CYC (TB_TMO)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_len      (wr_len),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_len      (rd_len),
    .rd_ack      (rd_ack),
    .rd_err      (rd_err),
    .m_init_txn  (m_init_txn),
    .m_base_addr (m_base_addr),
    .m_dir       (m_dir),
    .m_txn_done  (m_txn_done),
    .m_error     (m_error),
    .busy        (busy),
    .owner       (owner)
  );

  always #5 ACLK = ~ACLK;

  // Cycle counter used for latency predictions.
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Predicts one run: len inits spaced MST_LAT+1 apart starting the cycle
  // after the request is raised, cut short after an errored burst, then ack.
  function automatic void pushRun(input bit side, input logic [31:0] addr, input int len,
                                  input int errBurst, input int c, output int ackCyc);
    sbItem_t     it;
    int          issued = 0;
    logic [31:0] a = addr;
    for (int b = 0; b < len; b++) begin
      it.isAck = 1'b0; it.side = side; it.addr = a; it.err = 1'b0;
      it.cyc = c + 1 + b * (MST_LAT + 1);
      sbQ.push_back(it);
      issued++;
      a = a + 32'd64;
      if (errBurst == b + 1) break;
    end
    it.isAck = 1'b1; it.side = side; it.addr = '0;
    it.err = (errBurst > 0) && (errBurst <= len);
    it.cyc = c + 1 + issued * (MST_LAT + 1);
    sbQ.push_back(it);
    ackCyc = it.cyc;
  endfunction

  task automatic handleEvent(input bit isAck, input bit side, input logic [31:0] addr, input bit err);
    sbItem_t it;
    checkOutput("sb_event_expected", sbQ.size() > 0, 1);
    if (sbQ.size() > 0) begin
      it = sbQ.pop_front();
      checkOutput(isAck ? "ack_kind" : "init_kind", isAck, it.isAck);
      checkOutput(isAck ? "ack_side" : "init_dir", side, it.side);
      if (isAck) checkOutput("ack_err", err, it.err);
      else       checkOutput("init_addr", addr, it.addr);
      checkOutput(isAck ? "ack_cycle" : "init_cycle", cyc, it.cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from DUT updates.
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (m_init_txn) handleEvent(1'b0, m_dir, m_base_addr, 1'b0);
        if (wr_ack)     handleEvent(1'b1, 1'b0, 32'h0, wr_err);
        if (rd_ack)     handleEvent(1'b1, 1'b1, 32'h0, rd_err);
      end
    end
  end

  // Behavioural AXI master: done pulse MST_LAT cycles after each init,
  // with m_error on the burst numbered mstErrBurst within the current run.
  initial begin
    m_txn_done = 1'b0;
    m_error    = 1'b0;
    mstBursts  = 0;
    forever begin
      @(negedge ACLK);
      if (!busy) mstBursts = 0;
      while (m_init_txn) begin
        mstBursts++;
        repeat (MST_LAT) @(negedge ACLK);
        if (!mstHold) begin
          m_error    = (mstBursts == mstErrBurst);
          m_txn_done = 1'b1;
          @(negedge ACLK);
          m_txn_done = 1'b0;
          m_error    = 1'b0;
        end
      end
    end
  end

  // Registered-requester behaviour: raise now, drop when ack is seen.
  task automatic driveRequest(input bit side, input logic [31:0] addr, input logic [15:0] len);
    bit seen = 1'b0;
    if (side) begin rd_addr = addr; rd_len = len; rd_req = 1'b1; end
    else      begin wr_addr = addr; wr_len = len; wr_req = 1'b1; end
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge ACLK);
      if (side ? rd_ack : wr_ack) seen = 1'b1;
    end
    if (side) rd_req = 1'b0; else wr_req = 1'b0;
    if (!seen) checkOutput(side ? "rd_ack_timeout" : "wr_ack_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input bit side, input logic [31:0] addr, input int len, input int errBurst);
    int c, ackCyc;
    mstErrBurst = errBurst;
    @(negedge ACLK);
    c = cyc;
    pushRun(side, addr, len, errBurst, c, ackCyc);
    tbPrioRd = (side == 1'b0);
    driveRequest(side, addr, 16'(len));
    repeat (3) @(negedge ACLK);
  endtask

  // Both sides raise together; the bench's own pointer decides the order.
  task automatic applyStimulusPair(input logic [31:0] wa, input int wl, input logic [31:0] ra, input int rl);
    int c, ackA, ackB;
    bit rdFirst;
    mstErrBurst = 0;
    @(negedge ACLK);
    c = cyc;
    rdFirst = tbPrioRd;
    if (!rdFirst) begin
      pushRun(1'b0, wa, wl, 0, c, ackA);
      pushRun(1'b1, ra, rl, 0, ackA + 1, ackB);
    end else begin
      pushRun(1'b1, ra, rl, 0, c, ackA);
      pushRun(1'b0, wa, wl, 0, ackA + 1, ackB);
    end
    tbPrioRd = rdFirst;
    fork
      driveRequest(1'b0, wa, 16'(wl));
      driveRequest(1'b1, ra, 16'(rl));
    join
    repeat (3) @(negedge ACLK);
  endtask

  task automatic resetMidBurst();
    sbItem_t it;
    int c;
    mstErrBurst = 0;
    @(negedge ACLK);
    c = cyc;
    it.isAck = 1'b0; it.side = 1'b1; it.addr = 32'h8000_0000; it.err = 1'b0; it.cyc = c + 1;
    sbQ.push_back(it);
    rd_addr = 32'h8000_0000; rd_len = 16'd3; rd_req = 1'b1;
    repeat (6) @(negedge ACLK);
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_owner", owner, 1);
    checkOutput("pre_reset_base", m_base_addr, 32'h8000_0000);
    #2;
    ARESET = 1'b1;
    rd_req = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_dir", m_dir, 0);
    checkOutput("rst_base", m_base_addr, 0);
    checkOutput("rst_init", m_init_txn, 0);
    checkOutput("rst_acks", {wr_ack, rd_ack, wr_err, rd_err}, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    tbPrioRd = 1'b0;
    repeat (30) @(negedge ACLK);
  endtask

  initial begin
    ARESET = 1'b1;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0;
    mstErrBurst = 0;
    mstHold     = 1'b0;
    tbPrioRd    = 1'b0;
    repeat (3) @(negedge ACLK);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_owner", owner, 0);
    checkOutput("reset_init", m_init_txn, 0);
    checkOutput("reset_base", m_base_addr, 0);
    checkOutput("reset_acks", {wr_ack, rd_ack}, 0);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    $display("[TB] three-burst write");
    applyStimulus(1'b0, 32'h1000_0000, 3, 0);
    $display("[TB] zero-length read");
    applyStimulus(1'b1, 32'h2000_0000, 0, 0);
    $display("[TB] simultaneous requests, write side has priority");
    applyStimulusPair(32'h3000_0000, 1, 32'h4000_0000, 1);
    applyStimulus(1'b0, 32'h3100_0000, 1, 0);
    $display("[TB] simultaneous requests, read side has priority");
    applyStimulusPair(32'h5000_0000, 1, 32'h6000_0000, 1);
    $display("[TB] read with error on second burst");
    applyStimulus(1'b1, 32'h7000_0000, 4, 2);
    $display("[TB] address wrap");
    applyStimulus(1'b0, 32'hFFFF_FFC0, 2, 0);
    $display("[TB] reset during WAIT");
    resetMidBurst();
    applyStimulusPair(32'hA000_0000, 1, 32'hB000_0000, 1);

`ifdef DDR_SCHED_TIMEOUT_EN
    begin
      sbItem_t it;
      int c;
      $display("[TB] burst watchdog");
      mstHold = 1'b1;
      mstErrBurst = 0;
      @(negedge ACLK);
      c = cyc;
      it.isAck = 1'b0; it.side = 1'b0; it.addr = 32'h9000_0000; it.err = 1'b0; it.cyc = c + 1;
      sbQ.push_back(it);
      it.isAck = 1'b1; it.addr = '0; it.err = 1'b1; it.cyc = c + 2 + TB_TMO;
      sbQ.push_back(it);
      driveRequest(1'b0, 32'h9000_0000, 16'd1);
      tbPrioRd = 1'b1;
      repeat (30) @(negedge ACLK);
      mstHold = 1'b0;
    end
`endif

    repeat (5) @(negedge ACLK);
    checkOutput("sb_drained", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_burst_scheduler.md
# ddr_burst_scheduler

Shares the single AXI-Full master (M00_AXI) between two requesters: the ADC capture write path and the Ethernet readback path to DDR. Each granted request is a run of N fixed-size bursts. The scheduler pulses the master's INIT_AXI_TXN once per burst, advances the base address and waits for TXN_DONE. It aggregates ERROR into a one-cycle acknowledge back to the requester. The block sits between the capture/ETH control logic and the master_axi_full IP.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- LEN_W, 16, burst-count width
- BURST_BYTES, 64, address stride per burst (16 beats x 32 bit)
- TIMEOUT_CYC, 4096, max cycles waiting for one burst's done (used only with timeout feature)

Ports:
- ACLK  in  1  single clock for the whole block
- ARESET  in  1  asynchronous, active-high reset
- wr_req  in  1  ADC write request; level, held until wr_ack
- wr_addr  in  ADDR_W  write start address; sampled at grant
- wr_len  in  LEN_W  write burst count; sampled at grant
- wr_ack  out  1  one-cycle completion pulse
- wr_err  out  1  status; valid only while wr_ack=1
- rd_req, rd_addr, rd_len, rd_ack, rd_err  as above, for the ETH read side
- m_init_txn  out  1  one-cycle pulse to M00_AXI_INIT_AXI_TXN
- m_base_addr  out  ADDR_W  burst base address; stable from the init pulse until done
- m_dir  out  1  0 = write, 1 = read
- m_txn_done  in  1  M00_AXI_TXN_DONE (level)
- m_error  in  1  M00_AXI_ERROR
- busy  out  1  high whenever the state is not IDLE
- owner  out  1  current/last grant: 0 = wr, 1 = rd

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are arbitrated round-robin. When both are pending, the side not served last wins. After reset, wr wins.
  - On grant, latch owner, addr and len, and clear err_acc.
  - len=0 → RESP with err=0; no init is issued.
  - Otherwise → ISSUE.
- ISSUE:
  - m_init_txn=1 for exactly one cycle.
  - m_base_addr = current addr; m_dir = owner.
  - → WAIT.
- WAIT: the done event is a rising edge of m_txn_done, detected by the previous-value register. On the event:
  - err_acc |= m_error.
  - remaining -= 1.
  - addr += BURST_BYTES, modulo 2^ADDR_W (wraps silently).
  - If m_error=1 or remaining=0 → RESP; otherwise → ISSUE.
  - A burst error aborts the remaining bursts.
- RESP:
  - Pulse the owner's ack for one cycle, with err = err_acc.
  - Update the round-robin pointer.
  - → IDLE.
- Requests arriving while busy are held pending; none are lost.
- Requester rule: a registered requester drops req on the edge where it samples ack=1, so the requester is not re-granted in the following IDLE cycle.
- Reset (any time, including mid-burst):
  - state=IDLE; every output 0 (owner=0); round-robin pointer → wr.
  - The in-flight AXI transfer is not tracked. The master IP is reset on the same signal.

## Timing
- req high in IDLE at cycle N → m_init_txn high at N+1.
- len=0 → ack at N+1.
- Done edge sampled at cycle D:
  - next m_init_txn at D+1 if more bursts remain;
  - otherwise ack at D+1.
- Per-burst overhead: 2 cycles plus master latency.
- ack-to-next-grant: IDLE evaluates at the cycle after RESP. The earliest next init is RESP+2.
- A done edge outside WAIT is ignored, but it still updates the edge register.

## Configuration
- DDR_SCHED_TIMEOUT_EN defined:
  - A WAIT cycle counter is reset on entry to WAIT.
  - Reaching TIMEOUT_CYC with no done edge → err_acc=1 and → RESP.
- Undefined: no counter; WAIT waits indefinitely.

## Structure
- Package ddr_sched_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - owner enum {OWN_WR, OWN_RD};
  - default BURST_BYTES and TIMEOUT_CYC constants.
- One sub-module, ddr_sched_rr_arb: a two-input round-robin arbiter with a registered last-owner pointer and a grant-enable input.

## Test plan
- wr_req, addr 0x1000_0000, len 3; model done 20 cycles after each init → three inits at base 0x1000_0000, 0x1000_0040, 0x1000_0080, then wr_ack=1 with wr_err=0.
- wr_req and rd_req raised in the same cycle, len 1 each → wr served first, then rd. Repeat → rd served first.
- rd len 4; m_error=1 on the second done → exactly 2 inits, then rd_ack=1 with rd_err=1.
- wr_addr 0xFFFF_FFC0, len 2 → second base 0x0000_0000.
- len=0 → ack the next cycle, no m_init_txn.
- ARESET pulsed during WAIT → all outputs 0 immediately; the next request is granted to wr. With DDR_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, withholding done gives ack with err=1 at 16 cycles.
